tatzel_sar_ctrl: RTL and testbench
==================================

// Module: tatzel_sar_ctrl
// PURPOSE
//   Successive-approximation controller that digitises the analog reference output.
//   Drives the trial code to an off-block binary DAC and reads back one analog
//   comparator bit (reference > DAC). Resolves one bit per step, MSB first.
//   Instanced inside the tt_um top level: clocked by clk, comparator on a ua-derived
//   digital input, code/result exposed on uo_out/uio_out.
// PARAMETERS
//   WIDTH       8   conversion resolution in bits; also the dac_code and result width
//   SAMPLE_CYC  4   cycles sample is held high before bit resolution (>=1)
//   SETTLE_CYC  2   DAC settling cycles per bit, added to sync latency (>=0)
// PORTS
//   clk       in   1      clock
//   rst_n     in   1      asynchronous active-low reset
//   ena       in   1      block enable; low aborts any conversion
//   start     in   1      level-sampled conversion request, accepted only in IDLE
//   cmp_in    in   1      asynchronous comparator output, 1 = reference above DAC
//   sample    out  1      high during the SAMPLE phase (track switch)
//   dac_code  out  WIDTH  trial code driven to the DAC
//   busy      out  1      high from the accepting cycle through DONE
//   done      out  1      one-cycle pulse when result updates
//   result    out  WIDTH  last completed conversion, held until next done
// BEHAVIOUR
//   Reset (async): state IDLE; sample=0, dac_code=0, busy=0, done=0, result=0; sync flops=0.
//   FSM IDLE->SAMPLE->(SETTLE->DECIDE)xWIDTH->DONE->IDLE.
//   IDLE: if start&&ena at an edge, go to SAMPLE. start in any other state is ignored.
//   SAMPLE: lasts SAMPLE_CYC cycles, sample=1, dac_code=0. Exit sets bit idx=WIDTH-1
//     and code = 1<<(WIDTH-1).
//   SETTLE: lasts SETTLE_CYC+2 cycles (DAC settle + 2-flop sync). dac_code = trial code.
//   DECIDE (1 cycle): synced cmp=0 clears bit idx. cmp=1 keeps it.
//     idx==0: go to DONE. Else idx-1, set the next lower bit, go to SETTLE.
//   DONE (1 cycle): result<=code, done=1, busy=1. Next cycle: IDLE, dac_code=0.
//   Latency: if start is accepted at edge k, done is high in cycle
//     k + SAMPLE_CYC + WIDTH*(SETTLE_CYC+3) + 1. Defaults give 45.
//   start held high: the next conversion is accepted on the first IDLE cycle after DONE.
//   ena low in any non-IDLE state: next edge goes to IDLE, dac_code=0, sample=0.
//     No done. result unchanged.
//   Async reset mid-conversion: all outputs return to reset values immediately.
//   cmp stuck 1 -> result all ones. cmp stuck 0 -> result 0. No overflow possible.
// CONFIGURATION
//   TATZEL_SAR_AVG_EN defined:
//     - One request runs 4 full conversions (each with its own SAMPLE).
//     - Codes are summed into a WIDTH+2 bit accumulator, cleared on accept.
//     - Single done after the 4th conversion; result = acc[WIDTH+1:2] (truncating mean).
//     - Latency = 4x the single-conversion figure minus 3 (the 3 inner DONE cycles are skipped).
//   Not defined: single conversion, no accumulator logic present.
// STRUCTURE
//   Package tatzel_sar_pkg:
//     - state enum typedef (IDLE,SAMPLE,SETTLE,DECIDE,DONE)
//     - localparam SYNC_STAGES=2
//     - localparam AVG_LOG2=2
//   Sub-module tatzel_sync2: 2-flop synchronizer for cmp_in, async active-low reset to 0.
//   Settle/sample counter shared: width $clog2(max(SAMPLE_CYC,SETTLE_CYC+2)+1).
// TESTING
//   1 Reset asserted mid-run -> all outputs 0 in the same cycle; after release, IDLE, busy=0.
//   2 Ideal comparator model, reference code 0xA5, start pulse at edge k
//     -> dac_code trials 80,C0,A0,B0,A8,A4,A6,A5; done at k+45; result=0xA5.
//   3 cmp_in tied 1 -> result 0xFF. Tied 0 -> result 0x00. Exactly one done each.
//   4 start held high across 2 conversions -> second busy rises 1 cycle after first done.
//     start pulses while busy -> no extra conversion.
//   5 ena dropped at cycle k+20 -> busy=0 and dac_code=0 at k+21; no done; result keeps prior value.
//   6 TATZEL_SAR_AVG_EN, model codes 10,11,12,14 -> single done; result=0x0B (47>>2).

Source files
------------

// File: rtl/tatzel_sar_pkg.sv
// Shared types and constants for the tatzel SAR conversion controller.
package tatzel_sar_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSample,
        StSettle,
        StDecide,
        StDone
    } sar_state_e;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned AVG_LOG2    = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tatzel_sync2.sv
// Two-flop synchronizer bringing the asynchronous comparator bit into the clk domain.
module tatzel_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign dout = sync_q[1];

endmodule

// File: rtl/tatzel_sar_ctrl.sv
// Successive-approximation controller: MSB-first binary search driving an external DAC.
// Optional build macro TATZEL_SAR_AVG_EN averages four conversions per request.
module tatzel_sar_ctrl
    import tatzel_sar_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SAMPLE_CYC = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Settle window also hides the synchronizer latency of the comparator bit.
    localparam int unsigned SETTLE_LEN = SETTLE_CYC + SYNC_STAGES;
    localparam int unsigned CNT_W      = $clog2(max_u(SAMPLE_CYC, SETTLE_LEN) + 1);
    localparam int unsigned IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CODE_MSB    = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] CODE_LSB    = {{(WIDTH - 1){1'b0}}, 1'b1};

    sar_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] code_dec;
    logic             cmp_sync;

`ifdef TATZEL_SAR_AVG_EN
    localparam int unsigned ACC_W = WIDTH + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0] avg_q, avg_d;
`endif

    tatzel_sync2 u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cmp_in),
        .dout  (cmp_sync)
    );

    assign bit_mask = CODE_LSB << idx_q;
    // Comparator low means the trial overshot the reference: drop the bit under test.
    assign code_dec = cmp_sync ? code_q : (code_q & ~bit_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            code_q   <= '0;
            result_q <= '0;
`ifdef TATZEL_SAR_AVG_EN
            acc_q    <= '0;
            avg_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            code_q   <= code_d;
            result_q <= result_d;
`ifdef TATZEL_SAR_AVG_EN
            acc_q    <= acc_d;
            avg_q    <= avg_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        code_d   = code_q;
        result_d = result_q;
`ifdef TATZEL_SAR_AVG_EN
        acc_d    = acc_q;
        avg_d    = avg_q;
        acc_sum  = acc_q + ACC_W'(code_dec);
`endif
        if (!ena && (state_q != StIdle)) begin
            state_d = StIdle;
            code_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && ena) begin
                        state_d = StSample;
                        cnt_d   = SAMPLE_LOAD;
                        code_d  = '0;
`ifdef TATZEL_SAR_AVG_EN
                        acc_d   = '0;
                        avg_d   = '0;
`endif
                    end
                end
                StSample: begin
                    if (cnt_q == '0) begin
                        state_d = StSettle;
                        cnt_d   = SETTLE_LOAD;
                        idx_d   = IDX_MSB;
                        code_d  = CODE_MSB;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        state_d = StDecide;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StDecide: begin
                    code_d = code_dec;
                    if (idx_q == '0) begin
`ifdef TATZEL_SAR_AVG_EN
                        if (avg_q == '1) begin
                            result_d = acc_sum[ACC_W-1:AVG_LOG2];
                            state_d  = StDone;
                        end else begin
                            // Inner conversions skip DONE and resample immediately.
                            acc_d   = acc_sum;
                            avg_d   = avg_q + 1'b1;
                            state_d = StSample;
                            cnt_d   = SAMPLE_LOAD;
                        end
`else
                        result_d = code_dec;
                        state_d  = StDone;
`endif
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        code_d  = code_dec | (bit_mask >> 1);
                        state_d = StSettle;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    code_d  = '0;
                end
                default: begin
                    state_d = StIdle;
                    code_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        sample   = (state_q == StSample);
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        result   = result_q;
        dac_code = '0;
        if ((state_q == StSettle) || (state_q == StDecide) || (state_q == StDone)) begin
            dac_code = code_q;
        end
    end

endmodule

// File: tb/tb_tatzel_sar_ctrl.sv
// Directed self-checking bench for tatzel_sar_ctrl with an ideal comparator model.
module tb_tatzel_sar_ctrl;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned SAMPLE_CYC = 4;
    localparam int unsigned SETTLE_CYC = 2;
    // Edges from accept edge k to the edge that closes the done cycle.
    localparam int LAT1 = SAMPLE_CYC + WIDTH * (SETTLE_CYC + 3) + 1;
`ifdef TATZEL_SAR_AVG_EN
    localparam int LAT = 4 * LAT1 - 3;
`else
    localparam int LAT = LAT1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic       cmp_force_en = 1'b0;
    logic       cmp_force_val = 1'b0;
    logic [7:0] ref_code = 8'h00;
    logic       cmp_in;
    logic       sample;
    logic       busy;
    logic       done;
    logic [7:0] dac_code;
    logic [7:0] result;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] trials [8];
    int         n_trials;
    logic [7:0] conv_res;
    int         conv_lat;
    int         extra_done;

    always #5 clk = ~clk;

    // Reference sits half an LSB above ref_code, so equality keeps the bit.
    assign cmp_in = cmp_force_en ? cmp_force_val : (ref_code >= dac_code);

    tatzel_sar_ctrl #(
        .WIDTH      (WIDTH),
        .SAMPLE_CYC (SAMPLE_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .cmp_in   (cmp_in),
        .sample   (sample),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start from IDLE and follows the conversion up to its done pulse.
    task automatic convert();
        logic [7:0] prev;
        bit         got;
        int         cyc;
        prev = 8'h00; got = 1'b0; cyc = 0;
        n_trials = 0; conv_lat = -1; extra_done = 0; conv_res = 8'hxx;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!got && cyc < 1000) begin
            if (dac_code !== prev && dac_code !== 8'h00) begin
                if (n_trials < 8) trials[n_trials] = dac_code;
                n_trials++;
            end
            prev = dac_code;
            if (done === 1'b1) begin
                got = 1'b1;
                conv_lat = cyc + 1;
                conv_res = result;
            end else begin
                tick();
                cyc++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) extra_done++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; start = 1'b0;
        tick(); tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (sample !== 1'b0) begin fails++; $display("FAIL reset_sample got %b exp 0", sample); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (dac_code !== 8'h00) begin fails++; $display("FAIL reset_dac got %h exp 00", dac_code); end
        tests++; if (result !== 8'h00) begin fails++; $display("FAIL reset_result got %h exp 00", result); end
        rst_n = 1'b1; ena = 1'b1;
        tick(); tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_ideal_a5();
        logic [7:0] exp_tr [8];
        exp_tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        ref_code = 8'hA5;
        convert();
        tests++; if (conv_lat != LAT) begin fails++; $display("FAIL a5_latency got %0d exp %0d", conv_lat, LAT); end
        tests++; if (conv_res !== 8'hA5) begin fails++; $display("FAIL a5_result got %h exp a5", conv_res); end
        tests++; if (extra_done != 0) begin fails++; $display("FAIL a5_extra_done got %0d exp 0", extra_done); end
`ifndef TATZEL_SAR_AVG_EN
        tests++; if (n_trials != 8) begin fails++; $display("FAIL a5_ntrials got %0d exp 8", n_trials); end
`endif
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (trials[i] !== exp_tr[i]) begin
                fails++;
                $display("FAIL a5_trial%0d got %h exp %h", i, trials[i], exp_tr[i]);
            end
        end
        tests++; if (result !== 8'hA5) begin fails++; $display("FAIL a5_held got %h exp a5", result); end
        tests++; if (dac_code !== 8'h00) begin fails++; $display("FAIL a5_dac_idle got %h exp 00", dac_code); end
    endtask

    task automatic test_reset_mid();
        ref_code = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got %b exp 1", busy); end
        #3 rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b exp 0", busy); end
        tests++; if (sample !== 1'b0) begin fails++; $display("FAIL mid_sample got %b exp 0", sample); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL mid_done got %b exp 0", done); end
        tests++; if (dac_code !== 8'h00) begin fails++; $display("FAIL mid_dac got %h exp 00", dac_code); end
        tests++; if (result !== 8'h00) begin fails++; $display("FAIL mid_result got %h exp 00", result); end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_release_busy got %b exp 0", busy); end
        tests++; if (dac_code !== 8'h00) begin fails++; $display("FAIL mid_release_dac got %h exp 00", dac_code); end
    endtask

    task automatic test_stuck();
        cmp_force_en = 1'b1;
        cmp_force_val = 1'b1;
        convert();
        tests++; if (conv_res !== 8'hFF) begin fails++; $display("FAIL stuck1_result got %h exp ff", conv_res); end
        tests++; if (conv_lat != LAT) begin fails++; $display("FAIL stuck1_latency got %0d exp %0d", conv_lat, LAT); end
        tests++; if (extra_done != 0) begin fails++; $display("FAIL stuck1_extra got %0d exp 0", extra_done); end
        cmp_force_val = 1'b0;
        convert();
        tests++; if (conv_res !== 8'h00) begin fails++; $display("FAIL stuck0_result got %h exp 00", conv_res); end
        tests++; if (conv_lat != LAT) begin fails++; $display("FAIL stuck0_latency got %0d exp %0d", conv_lat, LAT); end
        tests++; if (extra_done != 0) begin fails++; $display("FAIL stuck0_extra got %0d exp 0", extra_done); end
        cmp_force_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  cyc;
        int  n_done;
        bit  got;
        ref_code = 8'h5A;
        start = 1'b1;
        tick();
        cyc = 0;
        while (done !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
        tests++; if (result !== 8'h5A) begin fails++; $display("FAIL b2b_first got %h exp 5a", result); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_gap_busy got %b exp 0", busy); end
        tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_rearm_busy got %b exp 1", busy); end
        tests++; if (sample !== 1'b1) begin fails++; $display("FAIL b2b_rearm_sample got %b exp 1", sample); end
        start = 1'b0;
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        start = 1'b1; tick(); start = 1'b0;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 1000) begin
            if (done === 1'b1) got = 1'b1;
            else begin tick(); cyc++; end
        end
        tests++; if (!got) begin fails++; $display("FAIL b2b_second_done got timeout exp done"); end
        n_done = 0;
        repeat (250) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        tests++; if (n_done != 0) begin fails++; $display("FAIL b2b_extra_conv got %0d exp 0", n_done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_abort();
        int n_done;
        ref_code = 8'hC3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before got %b exp 1", busy); end
        ena = 1'b0;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", busy); end
        tests++; if (dac_code !== 8'h00) begin fails++; $display("FAIL abort_dac got %h exp 00", dac_code); end
        tests++; if (sample !== 1'b0) begin fails++; $display("FAIL abort_sample got %b exp 0", sample); end
        n_done = 0;
        repeat (3) begin tick(); if (done === 1'b1) n_done++; end
        ena = 1'b1;
        repeat (60) begin tick(); if (done === 1'b1) n_done++; end
        tests++; if (n_done != 0) begin fails++; $display("FAIL abort_done got %0d exp 0", n_done); end
        tests++; if (result !== 8'h5A) begin fails++; $display("FAIL abort_result got %h exp 5a", result); end
    endtask

`ifdef TATZEL_SAR_AVG_EN
    task automatic test_avg();
        logic [7:0] codes [4];
        int         conv_idx;
        int         cyc;
        int         n_done;
        int         first_lat;
        logic [7:0] res;
        logic       prev_sample;
        codes = '{8'd10, 8'd11, 8'd12, 8'd14};
        conv_idx = 0; n_done = 0; first_lat = -1; res = 8'hxx;
        ref_code = codes[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        prev_sample = 1'b1;
        for (cyc = 0; cyc < 300; cyc++) begin
            if (sample === 1'b1 && prev_sample === 1'b0 && conv_idx < 3) begin
                conv_idx++;
                ref_code = codes[conv_idx];
            end
            prev_sample = sample;
            if (done === 1'b1) begin
                n_done++;
                if (first_lat < 0) begin first_lat = cyc + 1; res = result; end
            end
            tick();
        end
        tests++; if (n_done != 1) begin fails++; $display("FAIL avg_ndone got %0d exp 1", n_done); end
        tests++; if (res !== 8'h0B) begin fails++; $display("FAIL avg_result got %h exp 0b", res); end
        tests++; if (first_lat != LAT) begin fails++; $display("FAIL avg_latency got %0d exp %0d", first_lat, LAT); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ideal_a5();
        test_reset_mid();
        test_stuck();
        test_back_to_back();
        test_abort();
`ifdef TATZEL_SAR_AVG_EN
        test_avg();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
